phase_word_scheduler: RTL

Shares one serial restoring divider between NUM_CH frequency requesters (receiver and transmitter NCOs). It converts each channel's frequency in Hz to a 32-bit NCO phase increment, floor(freq × 2^32 / CLK_HZ). Channel frequency changes are detected automatically and serviced round-robin. The block sits between the control-bus frequency registers and the NCO phase accumulators.

---
 rtl/phase_word_scheduler.sv | 114 +++++++++++
 1 files changed

// File: rtl/phase_word_scheduler.sv
// Round-robin scheduler sharing one serial restoring divider that converts each
// channel frequency into a 32-bit NCO phase increment: floor(freq * 2^32 / CLK_HZ).
module phase_word_scheduler #(
    parameter int          NUM_CH = 4,
    parameter logic [31:0] CLK_HZ = 32'd122880000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH*32-1:0] freq_in,
    output logic [NUM_CH*32-1:0] phase_word,
    output logic [NUM_CH-1:0]    phase_valid,
    output logic                 busy,
    output logic [NUM_CH-1:0]    overflow
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, DIV, STORE} state_t;

    state_t               state;
    logic [NUM_CH*32-1:0] freq_last;
    logic [NUM_CH-1:0]    pending;
    logic [NUM_CH-1:0]    change;
    logic [NUM_CH-1:0]    grant;
    logic                 grant_any;
    logic [CW-1:0]        grant_idx;
    logic [CW-1:0]        last_grant;
    logic [CW-1:0]        cur;
    logic                 sat;
    logic [31:0]          snap;
    logic [95:0]          qr;
    logic [6:0]           count;
    logic [32:0]          rem_sh;
    logic [32:0]          diff;

    function automatic logic [CW-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CW-1:0]     last);
        logic [CW-1:0] pick;
        logic [CW-1:0] idx;
        pick = last;
        // Walk the search order backwards so the first requester after 'last' wins.
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = CW'((int'(last) + k) % NUM_CH);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign grant_any = (state == IDLE) && (|pending);
    assign grant_idx = rr_pick(pending, last_grant);
    assign snap      = freq_in[{grant_idx, 5'd0} +: 32];

    // Shift-then-compare: the remainder stays below CLK_HZ, so bit 32 of diff is the borrow.
    assign rem_sh = {qr[95:64], qr[63]};
    assign diff   = rem_sh - {1'b0, CLK_HZ};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        change = '0;
        grant  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            change[c] = (freq_in[32*c +: 32] != freq_last[32*c +: 32]);
            grant[c]  = grant_any && (grant_idx == CW'(c));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            freq_last   <= '0;
            pending     <= '1;
            last_grant  <= CW'(NUM_CH - 1);
            cur         <= '0;
            sat         <= 1'b0;
            qr          <= '0;
            count       <= '0;
            phase_word  <= '0;
            phase_valid <= '0;
            busy        <= 1'b0;
            overflow    <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every read sees pre-edge values.
            freq_last   <= freq_in;
            pending     <= (pending & ~grant) | change;
            phase_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cur   <= grant_idx;
                        sat   <= (snap >= CLK_HZ);
                        qr    <= {32'd0, snap, 32'd0};
                        count <= 7'd64;
                        busy  <= 1'b1;
                        state <= DIV;
                    end
                end
                DIV: begin
                    if (diff[32]) qr <= {qr[94:0], 1'b0};
                    else          qr <= {diff[31:0], qr[62:0], 1'b1};
                    count <= count - 7'd1;
                    if (count == 7'd1) state <= STORE;
                end
                STORE: begin
                    phase_word[{cur, 5'd0} +: 32] <= sat ? 32'hFFFF_FFFF : qr[31:0];
                    overflow[cur]    <= sat;
                    phase_valid[cur] <= 1'b1;
                    last_grant       <= cur;
                    busy             <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
